// File: rtl/g2_table_update_ctrl_if.sv
// g2_table_update_ctrl_if
//   Lookup and rule-update handshake bundle for one G2 table controller.
//   master : request side (lookup pipeline / update path drivers)
//   slave  : g2_table_update_ctrl
//   Lookup : lk_valid, lk_addr -> lk_ready, lk_rdata_valid, lk_rdata
//   Update : upd_valid, upd_op, upd_addr, upd_entry -> upd_ready,
//            upd_done, upd_err, upd_idx
interface g2_table_update_ctrl_if;
    logic         lk_valid;
    logic         lk_ready;
    logic [10:0]  lk_addr;
    logic         lk_rdata_valid;
    logic [170:0] lk_rdata;

    logic         upd_valid;
    logic         upd_ready;
    logic [1:0]   upd_op;
    logic [10:0]  upd_addr;
    logic [170:0] upd_entry;
    logic         upd_done;
    logic         upd_err;
    logic [10:0]  upd_idx;

    modport master (
        output lk_valid, lk_addr, upd_valid, upd_op, upd_addr, upd_entry,
        input  lk_ready, lk_rdata_valid, lk_rdata,
               upd_ready, upd_done, upd_err, upd_idx
    );

    modport slave (
        input  lk_valid, lk_addr, upd_valid, upd_op, upd_addr, upd_entry,
        output lk_ready, lk_rdata_valid, lk_rdata,
               upd_ready, upd_done, upd_err, upd_idx
    );
endinterface

// File: rtl/g2_table_update_ctrl.sv
// g2_table_update_ctrl
//   Sequencer and port arbiter for one single-port G2 table memory.
//   Shares the table port between lookups and rule insert / delete /
//   overwrite. Deletes compact by moving the last valid rule into the hole,
//   so valid rules always occupy indices 0..count-1.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       lookup + update handshakes (see g2_table_update_ctrl_if)
//   count             number of valid entries
//   tbl_we/addr/din   table write/read port
//   tbl_dout          table registered read data (1-cycle latency)
module g2_table_update_ctrl #(
    parameter int TABLE_ENTRY_SIZE = 18,
    parameter int INIT_COUNT       = 0,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    g2_table_update_ctrl_if.slave   bus,
    output logic [10:0]             count,
    output logic                    tbl_we,
    output logic [10:0]             tbl_addr,
    output logic [170:0]            tbl_din,
    input  logic [170:0]            tbl_dout
);

    localparam int          SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [10:0] CAPACITY   = 11'(TABLE_ENTRY_SIZE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INS_WR,
        S_OVR_WR,
        S_DEL_RD,
        S_DEL_WAIT,
        S_DEL_WR,
        S_DEL_CLR,
        S_DONE
    } state_t;

    state_t         state;
    logic [10:0]    addr_q;
    logic [170:0]   entry_q;
    logic [170:0]   hold_q;
    logic [SW-1:0]  starve_cnt;

    logic           access;
    logic           lk_grant;
    logic           fsm_grant;
    logic [10:0]    last_idx;

    assign access = (state == S_INS_WR) || (state == S_OVR_WR) ||
                    (state == S_DEL_RD) || (state == S_DEL_WR) ||
                    (state == S_DEL_CLR);

    // Lookups own the port unless a pending access has lost STARVE_LIMIT times.
    assign bus.lk_ready = !(access && (starve_cnt == STARVE_MAX));
    assign lk_grant     = bus.lk_valid && bus.lk_ready;
    assign fsm_grant    = access && !lk_grant && !rst;
    assign last_idx     = count - 11'd1;

    assign bus.lk_rdata  = tbl_dout;
    assign bus.upd_ready = (state == S_IDLE) && !rst;

    // Write data keeps the upper rule fields and stamps the destination
    // index into bits [10:0].
    always_comb begin
        tbl_we   = 1'b0;
        tbl_addr = bus.lk_addr;
        tbl_din  = '0;
        if (fsm_grant) begin
            case (state)
                S_INS_WR: begin
                    tbl_we        = 1'b1;
                    tbl_addr      = count;
                    tbl_din       = entry_q;
                    tbl_din[10:0] = count;
                end
                S_OVR_WR: begin
                    tbl_we        = 1'b1;
                    tbl_addr      = addr_q;
                    tbl_din       = entry_q;
                    tbl_din[10:0] = addr_q;
                end
                S_DEL_RD: begin
                    tbl_addr = last_idx;
                end
                S_DEL_WR: begin
                    tbl_we        = 1'b1;
                    tbl_addr      = addr_q;
                    tbl_din       = hold_q;
                    tbl_din[10:0] = addr_q;
                end
                S_DEL_CLR: begin
                    tbl_we   = 1'b1;
                    tbl_addr = last_idx;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            count              <= 11'(INIT_COUNT);
            starve_cnt         <= '0;
            addr_q             <= '0;
            entry_q            <= '0;
            hold_q             <= '0;
            bus.upd_done       <= 1'b0;
            bus.upd_err        <= 1'b0;
            bus.upd_idx        <= '0;
            bus.lk_rdata_valid <= 1'b0;
        end else begin
            bus.lk_rdata_valid <= lk_grant;
            bus.upd_done       <= 1'b0;
            bus.upd_err        <= 1'b0;

            if (access && !fsm_grant)
                starve_cnt <= starve_cnt + SW'(1);
            else
                starve_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (bus.upd_valid) begin
                        addr_q  <= bus.upd_addr;
                        entry_q <= bus.upd_entry;
                        case (bus.upd_op)
                            2'd0: begin
                                if (count == CAPACITY) begin
                                    state        <= S_DONE;
                                    bus.upd_done <= 1'b1;
                                    bus.upd_err  <= 1'b1;
                                end else begin
                                    state <= S_INS_WR;
                                end
                            end
                            2'd1: begin
                                if (bus.upd_addr >= count) begin
                                    state        <= S_DONE;
                                    bus.upd_done <= 1'b1;
                                    bus.upd_err  <= 1'b1;
                                end else if (bus.upd_addr == last_idx) begin
                                    state <= S_DEL_CLR;
                                end else begin
                                    state <= S_DEL_RD;
                                end
                            end
                            2'd2: begin
                                if (bus.upd_addr >= count) begin
                                    state        <= S_DONE;
                                    bus.upd_done <= 1'b1;
                                    bus.upd_err  <= 1'b1;
                                end else begin
                                    state <= S_OVR_WR;
                                end
                            end
                            default: begin
                                state        <= S_DONE;
                                bus.upd_done <= 1'b1;
                                bus.upd_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_INS_WR: begin
                    if (fsm_grant) begin
                        count        <= count + 11'd1;
                        bus.upd_idx  <= count;
                        bus.upd_done <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_OVR_WR: begin
                    if (fsm_grant) begin
                        bus.upd_idx  <= addr_q;
                        bus.upd_done <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DEL_RD: begin
                    if (fsm_grant)
                        state <= S_DEL_WAIT;
                end
                S_DEL_WAIT: begin
                    hold_q <= tbl_dout;
                    state  <= S_DEL_WR;
                end
                S_DEL_WR: begin
                    if (fsm_grant)
                        state <= S_DEL_CLR;
                end
                S_DEL_CLR: begin
                    if (fsm_grant) begin
                        count        <= last_idx;
                        bus.upd_idx  <= last_idx;
                        bus.upd_done <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_g2_table_update_ctrl.sv
module tb_g2_table_update_ctrl;

    localparam int TES  = 18;
    localparam int INIT = 3;
    localparam int SL   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    g2_table_update_ctrl_if bus();

    logic [10:0]  count;
    logic         tbl_we;
    logic [10:0]  tbl_addr;
    logic [170:0] tbl_din;
    logic [170:0] tbl_dout;

    g2_table_update_ctrl #(
        .TABLE_ENTRY_SIZE (TES),
        .INIT_COUNT       (INIT),
        .STARVE_LIMIT     (SL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .count    (count),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_din  (tbl_din),
        .tbl_dout (tbl_dout)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic        err;
        logic [10:0] idx;
        logic [10:0] cnt;
        int          due;
        bit          chk_idx;
    } done_t;

    typedef struct {
        logic [10:0]  addr;
        logic [170:0] din;
    } wr_t;

    done_t        done_q[$];
    wr_t          wr_q[$];
    logic [170:0] lk_q[$];
    logic [170:0] exp_tbl [0:31];
    logic [170:0] mem     [0:31];

    int   stall_n   = 0;
    int   stall_cyc = 0;
    logic stall_we  = 1'b0;
    int   lk_rx     = 0;

    function automatic logic [170:0] ent(input logic [31:0] seed, input logic [10:0] idx);
        logic [170:0] v;
        v = '0;
        for (int i = 0; i < 171; i++) v[i] = seed[i % 32];
        v[10:0] = idx;
        return v;
    endfunction

    task automatic check(input string name, input logic [170:0] act, input logic [170:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Table memory stand-in: single port, registered read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 3; i++) mem[i] <= ent(32'd100 + i, 11'(i));
        end else if (tbl_we) begin
            mem[tbl_addr[4:0]] <= tbl_din;
        end
        tbl_dout <= mem[tbl_addr[4:0]];
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.lk_valid && bus.lk_ready)
                lk_q.push_back(exp_tbl[bus.lk_addr[4:0]]);
            if (bus.lk_valid && !bus.lk_ready) begin
                stall_n++;
                stall_cyc = cyc;
                stall_we  = tbl_we;
            end
            if (bus.lk_rdata_valid) begin
                lk_rx++;
                if (lk_q.size() == 0) check("lk_unexpected", 1'b1, 1'b0);
                else                  check("lk_rdata", bus.lk_rdata, lk_q.pop_front());
            end
            if (tbl_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("wr_addr", tbl_addr, w.addr);
                    check("wr_din", tbl_din, w.din);
                end
            end
            if (bus.upd_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_cycle", 171'(cyc), 171'(d.due));
                    check("upd_err", bus.upd_err, d.err);
                    check("count_at_done", count, d.cnt);
                    if (d.chk_idx) check("upd_idx", bus.upd_idx, d.idx);
                end
            end
        end
    end

    task automatic exp_wr(input logic [10:0] a, input logic [170:0] d);
        wr_q.push_back('{a, d});
        exp_tbl[a[4:0]] = d;
    endtask

    // lat < 0: no completion expected (operation will be abandoned).
    task automatic do_upd(input logic [1:0] op, input logic [10:0] addr, input logic [170:0] e,
                          input int lat, input logic err, input logic [10:0] idx,
                          input logic [10:0] cnt, input bit chk_idx, output int t_acc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.upd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL upd_ready_timeout: upd_ready stayed 0, required 1");
        end
        bus.upd_op    = op;
        bus.upd_addr  = addr;
        bus.upd_entry = e;
        bus.upd_valid = 1'b1;
        t_acc = cyc;
        if (lat >= 0) done_q.push_back('{err, idx, cnt, cyc + lat, chk_idx});
        @(posedge clk); #1;
        bus.upd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done_q.size() == 0 && wr_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: pending done=%0d writes=%0d, required 0", name,
                     done_q.size(), wr_q.size());
            done_q.delete();
            wr_q.delete();
        end
    endtask

    localparam logic [31:0] SA = 32'hA5A5_1234;
    localparam logic [31:0] SB = 32'h5A5A_C0DE;
    localparam logic [31:0] SC = 32'h1357_9BDF;
    localparam logic [31:0] SD = 32'hDEAD_BEEF;
    localparam logic [31:0] SG = 32'h0BAD_F00D;

    initial begin
        int t;
        int rx0;
        bus.lk_valid  = 1'b0;
        bus.lk_addr   = '0;
        bus.upd_valid = 1'b0;
        bus.upd_op    = '0;
        bus.upd_addr  = '0;
        bus.upd_entry = '0;
        for (int i = 0; i < 32; i++) exp_tbl[i] = '0;
        for (int i = 0; i < 3; i++) exp_tbl[i] = ent(32'd100 + i, 11'(i));

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_count", count, 11'd3);
        check("rst_upd_done", bus.upd_done, 1'b0);
        check("rst_upd_ready", bus.upd_ready, 1'b0);
        check("rst_lk_rdata_valid", bus.lk_rdata_valid, 1'b0);
        check("rst_tbl_we", tbl_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Insert at count 3 -> index 3, count 4
        exp_wr(11'd3, ent(SA, 11'd3));
        do_upd(2'd0, 11'd0, ent(SA, 11'h7FF), 2, 1'b0, 11'd3, 11'd4, 1'b1, t);
        wait_drain("ins_a");
        // Insert -> index 4, count 5
        exp_wr(11'd4, ent(SB, 11'd4));
        do_upd(2'd0, 11'd0, ent(SB, 11'h555), 2, 1'b0, 11'd4, 11'd5, 1'b1, t);
        wait_drain("ins_b");
        // Delete out of range (addr 7, count 5)
        do_upd(2'd1, 11'd7, '0, 1, 1'b1, 11'd0, 11'd5, 1'b0, t);
        wait_drain("del_err");
        // Delete middle addr 1: entry 4 moves to 1, slot 4 cleared
        exp_wr(11'd1, ent(SB, 11'd1));
        exp_wr(11'd4, '0);
        do_upd(2'd1, 11'd1, '0, 5, 1'b0, 11'd4, 11'd4, 1'b1, t);
        wait_drain("del_mid");
        // Overwrite addr 2
        exp_wr(11'd2, ent(SC, 11'd2));
        do_upd(2'd2, 11'd2, ent(SC, 11'h0F0), 2, 1'b0, 11'd2, 11'd4, 1'b1, t);
        wait_drain("ovr");
        // Overwrite addr == count -> error
        do_upd(2'd2, 11'd4, ent(SC, 11'd0), 1, 1'b1, 11'd0, 11'd4, 1'b0, t);
        wait_drain("ovr_err");
        // Reserved op
        do_upd(2'd3, 11'd0, '0, 1, 1'b1, 11'd0, 11'd4, 1'b0, t);
        wait_drain("op3");
        // Delete last (addr 3, count 4)
        exp_wr(11'd3, '0);
        do_upd(2'd1, 11'd3, '0, 2, 1'b0, 11'd3, 11'd3, 1'b1, t);
        wait_drain("del_last");

        // Insert with continuous lookups: forced write 4 cycles into INS_WR
        stall_n = 0;
        bus.lk_addr  = 11'd0;
        bus.lk_valid = 1'b1;
        exp_wr(11'd3, ent(SD, 11'd3));
        do_upd(2'd0, 11'd0, ent(SD, 11'h123), 6, 1'b0, 11'd3, 11'd4, 1'b1, t);
        wait_drain("ins_starve");
        @(posedge clk); #1;
        bus.lk_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("starve_stall_count", 171'(stall_n), 171'(1));
        check("starve_stall_cycle", 171'(stall_cyc), 171'(t + 5));
        check("starve_stall_we", stall_we, 1'b1);

        // Delete addr 0 with a lookup during DEL_WAIT
        exp_wr(11'd0, ent(SD, 11'd0));
        exp_wr(11'd3, '0);
        rx0 = lk_rx;
        do_upd(2'd1, 11'd0, '0, 5, 1'b0, 11'd3, 11'd3, 1'b1, t);
        @(posedge clk); #1;
        bus.lk_addr  = 11'd1;
        bus.lk_valid = 1'b1;
        @(posedge clk); #1;
        bus.lk_valid = 1'b0;
        wait_drain("del_lookup");
        check("del_wait_lookup_rx", 171'(lk_rx - rx0), 171'(1));

        // Fill to capacity, then insert into a full table
        for (int k = 3; k <= TES; k++) begin
            exp_wr(11'(k), ent(32'hF00D_0000 + k, 11'(k)));
            do_upd(2'd0, 11'd0, ent(32'hF00D_0000 + k, 11'h7FF), 2, 1'b0, 11'(k), 11'(k + 1), 1'b1, t);
            wait_drain("fill");
        end
        check("count_full", count, 11'd19);
        do_upd(2'd0, 11'd0, ent(SA, 11'd0), 1, 1'b1, 11'd0, 11'd19, 1'b0, t);
        wait_drain("ins_full");

        // Reset during DEL_WR abandons the delete
        do_upd(2'd1, 11'd0, '0, -1, 1'b0, 11'd0, 11'd0, 1'b0, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_del_wr_no_we", tbl_we, 1'b0);
        @(posedge clk); #1;
        check("rst_mid_count", count, 11'd3);
        check("rst_mid_upd_done", bus.upd_done, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_mid_upd_ready", bus.upd_ready, 1'b1);

        // Normal insert after reset
        exp_wr(11'd3, ent(SG, 11'd3));
        do_upd(2'd0, 11'd0, ent(SG, 11'h3C3), 2, 1'b0, 11'd3, 11'd4, 1'b1, t);
        wait_drain("ins_after_rst");
        repeat (2) @(posedge clk);
        check("lk_queue_empty", 171'(lk_q.size()), 171'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
